// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: pattern modes and sweep direction.
// Latency: n/a (types only).
// Backpressure: n/a.
package led_pattern_pkg;

   // Pattern selected by MODE; encoding matches the 2-bit MODE input.
   typedef enum logic [1:0] {
      MODE_BLINK,
      MODE_CHASE,
      MODE_BOUNCE,
      MODE_BREATHE
   } mode_e;

   // Sweep direction shared by the bounce position and the breathe duty.
   typedef enum logic {
      DIR_UP,
      DIR_DOWN
   } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: free-running modulo-DIV counter producing one TICK per DIV enabled cycles.
// Latency: TICK is combinational from the registered count (high while cnt == DIV-1).
// Backpressure: none; ENABLE=0 holds the count and forces TICK low.
// Ports: CLK clock, RST async active-high reset, ENABLE run/freeze, TICK step strobe.
module led_prescaler #(
   parameter int DIV = 64
) (
   input  logic CLK,
   input  logic RST,
   input  logic ENABLE,
   output logic TICK
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ENABLE) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign TICK = ENABLE && (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink, chase, bounce or PWM breathe, stepped by a shared prescaler tick.
// Latency: LED is registered; a tick (or MODE change sampled at a tick) shows on LED after that edge.
// Backpressure: none; ENABLE=0 freezes every counter, LED, and holds STEP low.
// Ports: CLK clock, RST async active-high reset, ENABLE run/freeze, MODE requested pattern,
//        LED registered drive (1 = on), STEP high in the cycle a step tick occurs.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int N_LEDS = 8,
   parameter int DIV    = 64,
   parameter int PWM_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ENABLE,
   input  logic [1:0]        MODE,
   output logic [N_LEDS-1:0] LED,
   output logic              STEP
);

   localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
   localparam logic [PW-1:0]    POS_LAST = PW'(N_LEDS - 1);
   localparam logic [PWM_W-1:0] DUTY_MAX = '1;

   logic              tick;
   mode_e             mode_req;
   mode_e             mode_q,  mode_d;
   dir_e              dir_q,   dir_d;
   logic [PW-1:0]     pos_q,   pos_d;
   logic [PWM_W-1:0]  duty_q,  duty_d;
   logic [PWM_W-1:0]  pwm_q,   pwm_d;
   logic [N_LEDS-1:0] led_q,   led_d;

   led_prescaler #(.DIV(DIV)) u_prescaler (
      .CLK    (CLK),
      .RST    (RST),
      .ENABLE (ENABLE),
      .TICK   (tick)
   );

   assign mode_req = mode_e'(MODE);
   assign STEP     = tick;
   assign LED      = led_q;

   always_comb begin
      mode_d = mode_q;
      dir_d  = dir_q;
      pos_d  = pos_q;
      duty_d = duty_q;
      pwm_d  = pwm_q;
      led_d  = led_q;
      if (ENABLE) begin
         if (tick && (mode_req != mode_q)) begin
            // A mode change at a tick loads the entry state instead of advancing.
            mode_d = mode_req;
            pos_d  = '0;
            dir_d  = DIR_UP;
            duty_d = '0;
            pwm_d  = '0;
            case (mode_req)
               MODE_BLINK:   led_d = '1;
               MODE_BREATHE: led_d = '0;
               default:      led_d = N_LEDS'(1);
            endcase
         end else begin
            case (mode_q)
               MODE_BLINK: begin
                  if (tick) led_d = ~led_q;
               end
               MODE_CHASE: begin
                  if (tick) begin
                     pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
                     led_d = N_LEDS'(1) << pos_d;
                  end
               end
               MODE_BOUNCE: begin
                  if (tick) begin
                     // A single LED has nowhere to move; it stays lit at position 0.
                     if (N_LEDS == 1)          pos_d = '0;
                     else if (dir_q == DIR_UP) pos_d = pos_q + PW'(1);
                     else                      pos_d = pos_q - PW'(1);
                     // Turning on arrival lights each end LED for exactly one step per sweep.
                     if ((N_LEDS > 1) && (pos_d == POS_LAST)) dir_d = DIR_DOWN;
                     else if (pos_d == '0)                    dir_d = DIR_UP;
                     led_d = N_LEDS'(1) << pos_d;
                  end
               end
               MODE_BREATHE: begin
                  pwm_d = pwm_q + PWM_W'(1);
                  led_d = {N_LEDS{pwm_q < duty_q}};
                  if (tick) begin
                     duty_d = (dir_q == DIR_UP) ? duty_q + PWM_W'(1) : duty_q - PWM_W'(1);
                     if (duty_d == DUTY_MAX) dir_d = DIR_DOWN;
                     else if (duty_d == '0)  dir_d = DIR_UP;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mode_q <= MODE_BLINK;
         dir_q  <= DIR_UP;
         pos_q  <= '0;
         duty_q <= '0;
         pwm_q  <= '0;
         led_q  <= '0;
      end else begin
         mode_q <= mode_d;
         dir_q  <= dir_d;
         pos_q  <= pos_d;
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
         led_q  <= led_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: one DUT at default parameters, one at DIV=16 for breathe.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_pattern_gen;

   logic       clk = 1'b0;
   logic       rst, rst_b;
   logic       enable, enable_b;
   logic [1:0] mode, mode_b;
   logic [7:0] led, led_b;
   logic       step, step_b;

   always #5 clk = ~clk;

   led_pattern_gen dut (
      .CLK(clk), .RST(rst), .ENABLE(enable), .MODE(mode), .LED(led), .STEP(step)
   );

   led_pattern_gen #(.N_LEDS(8), .DIV(16), .PWM_W(4)) dut_b (
      .CLK(clk), .RST(rst_b), .ENABLE(enable_b), .MODE(mode_b), .LED(led_b), .STEP(step_b)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         duty_sb[$];

   // Waits (bounded) at negedges until STEP is high; n is the number of negedges waited.
   task automatic wait_step(output int n);
      n = 0;
      while (step !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Leaves the bench at the negedge just before edge 1.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (led !== 8'h00 || step !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: led=%h step=%b, want led=00 step=0", led, step);
      end
      checks++;
      if (led_b !== 8'h00 || step_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_b: led=%h step=%b, want led=00 step=0", led_b, step_b);
      end
   endtask

   task automatic test_blink();
      logic [7:0] exp_led;
      logic [7:0] want;
      mode = 2'd0;
      do_reset();
      exp_led = 8'h00;
      for (int k = 1; k <= 192; k++) begin
         checks++;
         if (step !== (k % 64 == 0)) begin
            errors++;
            $display("FAIL blink_step: before edge %0d step=%b want %b", k, step, (k % 64 == 0));
         end
         if (k % 64 == 0) begin
            exp_led = ~exp_led;
            exp_q.push_back(exp_led);
         end
         @(posedge clk); #1;
         want = (k % 64 == 0) ? exp_q.pop_front() : exp_led;
         checks++;
         if (led !== want) begin
            errors++;
            $display("FAIL blink_led: after edge %0d led=%h want %h", k, led, want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_chase();
      int n;
      logic [7:0] want;
      mode = 2'd1;
      do_reset();
      for (int t = 1; t <= 9; t++) exp_q.push_back(8'(1 << ((t - 1) % 8)));
      for (int t = 1; t <= 9; t++) begin
         wait_step(n);
         checks++;
         if (n != 63) begin
            errors++;
            $display("FAIL chase_gap: tick %0d after %0d cycles, want 63", t, n);
         end
         @(posedge clk); #1;
         want = exp_q.pop_front();
         checks++;
         if (led !== want) begin
            errors++;
            $display("FAIL chase_led: tick %0d led=%h want %h", t, led, want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_bounce();
      int n;
      logic [7:0] want;
      logic [7:0] seq [16];
      seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      mode = 2'd2;
      do_reset();
      for (int t = 0; t < 16; t++) exp_q.push_back(seq[t]);
      for (int t = 1; t <= 16; t++) begin
         wait_step(n);
         checks++;
         if (n != 63) begin
            errors++;
            $display("FAIL bounce_gap: tick %0d after %0d cycles, want 63", t, n);
         end
         @(posedge clk); #1;
         want = exp_q.pop_front();
         checks++;
         if (led !== want) begin
            errors++;
            $display("FAIL bounce_led: tick %0d led=%h want %h", t, led, want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_breathe();
      int cur;
      int win_hi;
      int i;
      logic [7:0] want;
      cur = 0;
      win_hi = 0;
      mode_b = 2'd3;
      enable_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      for (int e = 1; e <= 544; e++) begin
         checks++;
         if (step_b !== (e % 16 == 0)) begin
            errors++;
            $display("FAIL breathe_step: before edge %0d step=%b want %b", e, step_b, (e % 16 == 0));
         end
         if (e % 16 == 0) begin
            i = e / 16 - 1;
            duty_sb.push_back((i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30));
         end
         @(posedge clk); #1;
         if (e > 16 && (e - 1) % 16 == 0) cur = duty_sb.pop_front();
         want = (e > 16 && ((e - 1) % 16) < cur) ? 8'hFF : 8'h00;
         checks++;
         if (led_b !== want) begin
            errors++;
            $display("FAIL breathe_led: after edge %0d led=%h want %h (duty %0d)", e, led_b, want, cur);
         end
         if (led_b === 8'hFF) win_hi++;
         if (e > 16 && e % 16 == 0) begin
            checks++;
            if (win_hi != cur) begin
               errors++;
               $display("FAIL breathe_window: ending edge %0d high=%0d want %0d", e, win_hi, cur);
            end
         end
         if (e % 16 == 0) win_hi = 0;
         @(negedge clk);
      end
      duty_sb.delete();
   endtask

   task automatic test_freeze();
      int n;
      logic [7:0] want;
      mode = 2'd1;
      do_reset();
      repeat (222) @(posedge clk);
      #1;
      checks++;
      if (led !== 8'h04) begin
         errors++;
         $display("FAIL freeze_pre: led=%h want 04", led);
      end
      @(negedge clk);
      enable = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         checks++;
         if (led !== 8'h04) begin
            errors++;
            $display("FAIL freeze_led: cycle %0d led=%h want 04", c, led);
         end
         @(negedge clk);
         checks++;
         if (step !== 1'b0) begin
            errors++;
            $display("FAIL freeze_step: cycle %0d step=%b want 0", c, step);
         end
      end
      enable = 1'b1;
      exp_q.push_back(8'h08);
      wait_step(n);
      checks++;
      if (n != 33) begin
         errors++;
         $display("FAIL freeze_resume: step after %0d cycles, want 33", n);
      end
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if (led !== want) begin
         errors++;
         $display("FAIL freeze_led_after: led=%h want %h", led, want);
      end
      @(negedge clk);
   endtask

   task automatic test_mode_change();
      int n;
      logic [7:0] want;
      mode = 2'd1;
      do_reset();
      for (int t = 1; t <= 5; t++) exp_q.push_back(8'(1 << (t - 1)));
      for (int t = 1; t <= 5; t++) begin
         wait_step(n);
         @(posedge clk); #1;
         want = exp_q.pop_front();
         checks++;
         if (led !== want) begin
            errors++;
            $display("FAIL mode_glitch: tick %0d led=%h want %h", t, led, want);
         end
         @(negedge clk);
         if (t < 5) begin
            repeat (10) @(negedge clk);
            mode = 2'd2;
            repeat (10) @(negedge clk);
            mode = 2'd1;
         end
      end
      // Chase sits at 0x10; request breathe, which takes over at the next tick.
      mode = 2'd3;
      exp_q.push_back(8'h00);
      wait_step(n);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if (led !== want) begin
         errors++;
         $display("FAIL mode_breathe_entry: led=%h want %h", led, want);
      end
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         checks++;
         if (led !== 8'h00) begin
            errors++;
            $display("FAIL mode_breathe_duty0: cycle %0d led=%h want 00", c, led);
         end
      end
      @(negedge clk);
      // Change MODE in the tick cycle itself: entry must win over advance.
      wait_step(n);
      mode = 2'd0;
      exp_q.push_back(8'hFF);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if (led !== want) begin
         errors++;
         $display("FAIL mode_same_cycle: led=%h want %h", led, want);
      end
      @(negedge clk);
      // Asynchronous reset in the middle of a tick cycle.
      wait_step(n);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (led !== 8'h00 || step !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: led=%h step=%b, want led=00 step=0", led, step);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(8'hFF);
      wait_step(n);
      checks++;
      if (n != 63) begin
         errors++;
         $display("FAIL reset_resume_gap: step after %0d cycles, want 63", n);
      end
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if (led !== want) begin
         errors++;
         $display("FAIL reset_resume_led: led=%h want %h", led, want);
      end
      @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      rst_b    = 1'b1;
      enable   = 1'b1;
      enable_b = 1'b1;
      mode     = 2'd0;
      mode_b   = 2'd3;
      test_reset();
      test_blink();
      test_chase();
      test_bounce();
      test_breathe();
      test_freeze();
      test_mode_change();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
